// File: rtl/tug_pkg.sv
// Shared tug-of-war definitions: round state encoding, default playfield width, centre helper.
// Used by the round controller and the per-player score stage.
package tug_pkg;

  typedef enum logic {
    PLAY = 1'b0,
    HOLD = 1'b1
  } tug_state_t;

  localparam int TUG_N_LIGHTS = 9;

  function automatic int tug_centre(input int n_lights);
    return n_lights / 2;
  endfunction

endpackage

// File: rtl/tug_hold_timer.sv
// Round-over down-counter (only built with TUG_AUTO_RESTART_EN); done is high while the count is 0.
// start loads HOLD_CYCLES-1 so done lands on the last HOLD cycle; no backpressure.
module tug_hold_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic done
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (start) begin
      count <= LOAD;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/tug_round_ctrl.sv
// Tug-of-war round controller: press pulses move a one-hot light, registered one-cycle win pulses, HOLD then recentre.
// Press-to-LED and press-to-win latency 1 cycle; HOLD exit by timer with TUG_AUTO_RESTART_EN, else by any press.
module tug_round_ctrl
  import tug_pkg::*;
#(
  parameter int N_LIGHTS    = TUG_N_LIGHTS,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                press_l,
  input  logic                press_r,
  output logic [N_LIGHTS-1:0] leds,
  output logic                win_l,
  output logic                win_r,
  output logic                round_active
);

  localparam int POS_W = $clog2(N_LIGHTS);
  localparam logic [POS_W-1:0] CENTRE   = POS_W'(tug_centre(N_LIGHTS));
  localparam logic [POS_W-1:0] LEFT_END = POS_W'(N_LIGHTS - 1);
  localparam logic [POS_W-1:0] RIGHT_END = '0;

  if ((N_LIGHTS < 3) || ((N_LIGHTS % 2) == 0)) begin : g_bad_n_lights
    $error("tug_round_ctrl: N_LIGHTS must be odd and at least 3");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold_cycles
    $error("tug_round_ctrl: HOLD_CYCLES must be at least 1");
  end

  tug_state_t       state, state_n;
  logic [POS_W-1:0] pos, pos_n;
  logic             win_l_n, win_r_n;
  logic             move_l, move_r;

  // Simultaneous presses cancel, so only a lone press counts as a pull.
  assign move_l = press_l & ~press_r;
  assign move_r = press_r & ~press_l;

`ifdef TUG_AUTO_RESTART_EN
  logic hold_start;
  logic hold_done;

  tug_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk   (Clock),
    .rst   (Reset),
    .start (hold_start),
    .done  (hold_done)
  );
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= PLAY;
      pos   <= CENTRE;
      win_l <= 1'b0;
      win_r <= 1'b0;
    end else begin
      state <= state_n;
      pos   <= pos_n;
      win_l <= win_l_n;
      win_r <= win_r_n;
    end
  end

  always_comb begin
    state_n = state;
    pos_n   = pos;
    win_l_n = 1'b0;
    win_r_n = 1'b0;
`ifdef TUG_AUTO_RESTART_EN
    hold_start = 1'b0;
`endif
    case (state)
      PLAY: begin
        if (move_l) begin
          if (pos == LEFT_END) begin
            state_n = HOLD;
            win_l_n = 1'b1;
`ifdef TUG_AUTO_RESTART_EN
            hold_start = 1'b1;
`endif
          end else begin
            pos_n = pos + 1'b1;
          end
        end else if (move_r) begin
          if (pos == RIGHT_END) begin
            state_n = HOLD;
            win_r_n = 1'b1;
`ifdef TUG_AUTO_RESTART_EN
            hold_start = 1'b1;
`endif
          end else begin
            pos_n = pos - 1'b1;
          end
        end
      end
      HOLD: begin
        // The light stays on the winning end; the exit press itself never moves it.
`ifdef TUG_AUTO_RESTART_EN
        if (hold_done) begin
          state_n = PLAY;
          pos_n   = CENTRE;
        end
`else
        if (press_l || press_r) begin
          state_n = PLAY;
          pos_n   = CENTRE;
        end
`endif
      end
      default: begin
        state_n = PLAY;
        pos_n   = CENTRE;
      end
    endcase
  end

  assign leds         = {{(N_LIGHTS-1){1'b0}}, 1'b1} << pos;
  assign round_active = (state == PLAY);

endmodule

// File: tb/tb_tug_round_ctrl.sv
// Directed bench for tug_round_ctrl (N_LIGHTS=9, HOLD_CYCLES=4); expectations come from a behavioural
// model queued at drive time, plus fixed values from the round scenarios. Honours TUG_AUTO_RESTART_EN.
module tb_tug_round_ctrl;

  localparam int NL  = 9;
  localparam int HC  = 4;
  localparam int CEN = NL / 2;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          press_l = 1'b0;
  logic          press_r = 1'b0;
  logic [NL-1:0] leds;
  logic          win_l;
  logic          win_r;
  logic          round_active;

  tug_round_ctrl #(
    .N_LIGHTS    (NL),
    .HOLD_CYCLES (HC)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .press_l      (press_l),
    .press_r      (press_r),
    .leds         (leds),
    .win_l        (win_l),
    .win_r        (win_r),
    .round_active (round_active)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [NL-1:0] leds;
    logic          wl;
    logic          wr;
    logic          act;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int m_pos  = CEN;
  bit m_hold = 1'b0;
  int m_cnt  = 0;

  task automatic chk(input string tag, input logic [NL-1:0] obs, input logic [NL-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, predict with the model, queue the prediction, compare after the edge.
  task automatic step(input logic pl, input logic pr, input logic rst);
    exp_t e;
    logic wl;
    logic wr;
    wl = 1'b0;
    wr = 1'b0;
    @(negedge Clock);
    press_l = pl;
    press_r = pr;
    Reset   = rst;
    if (rst) begin
      m_pos  = CEN;
      m_hold = 1'b0;
      m_cnt  = 0;
    end else if (!m_hold) begin
      if (pl && !pr) begin
        if (m_pos == NL - 1) begin
          m_hold = 1'b1;
          wl     = 1'b1;
          m_cnt  = HC;
        end else begin
          m_pos = m_pos + 1;
        end
      end else if (pr && !pl) begin
        if (m_pos == 0) begin
          m_hold = 1'b1;
          wr     = 1'b1;
          m_cnt  = HC;
        end else begin
          m_pos = m_pos - 1;
        end
      end
    end else begin
`ifdef TUG_AUTO_RESTART_EN
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_hold = 1'b0;
        m_pos  = CEN;
      end
`else
      if (pl || pr) begin
        m_hold = 1'b0;
        m_pos  = CEN;
      end
`endif
    end
    e.leds        = '0;
    e.leds[m_pos] = 1'b1;
    e.wl          = wl;
    e.wr          = wr;
    e.act         = !m_hold;
    sb.push_back(e);
    @(posedge Clock);
    #1;
    e = sb.pop_front();
    chk("leds", leds, e.leds);
    chk("win_l", {8'b0, win_l}, {8'b0, e.wl});
    chk("win_r", {8'b0, win_r}, {8'b0, e.wr});
    chk("round_active", {8'b0, round_active}, {8'b0, e.act});
  endtask

  initial begin
    // Reset and release
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("reset_leds", leds, 9'b000010000);
    chk("reset_active", {8'b0, round_active}, 9'd1);
    chk("reset_wins", {7'b0, win_l, win_r}, 9'd0);

    // Pull to the left end, then win left
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    chk("left_end", leds, 9'b100000000);
    step(1'b1, 1'b0, 1'b0);
    chk("win_l_pulse", {8'b0, win_l}, 9'd1);
    chk("win_active_low", {8'b0, round_active}, 9'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("win_l_one_cycle", {8'b0, win_l}, 9'd0);
    chk("hold_leds", leds, 9'b100000000);

`ifdef TUG_AUTO_RESTART_EN
    repeat (3) step(1'b0, 1'b0, 1'b0);
    chk("auto_restart_leds", leds, 9'b000010000);
    chk("auto_restart_active", {8'b0, round_active}, 9'd1);
`else
    repeat (20) step(1'b0, 1'b0, 1'b0);
    chk("idle_hold_active", {8'b0, round_active}, 9'd0);
    chk("idle_hold_leds", leds, 9'b100000000);
    step(1'b0, 1'b1, 1'b0);
    chk("press_exit_leds", leds, 9'b000010000);
    chk("press_exit_active", {8'b0, round_active}, 9'd1);
    chk("press_exit_no_win", {8'b0, win_r}, 9'd0);
`endif

    // Simultaneous presses at centre and at the right end
    step(1'b1, 1'b1, 1'b0);
    chk("both_centre", leds, 9'b000010000);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    chk("right_end", leds, 9'b000000001);
    step(1'b1, 1'b1, 1'b0);
    chk("both_right_end", leds, 9'b000000001);
    chk("both_right_no_win", {8'b0, win_r}, 9'd0);

    // Right win, then presses every cycle during HOLD
    step(1'b0, 1'b1, 1'b0);
    chk("win_r_pulse", {8'b0, win_r}, 9'd1);
    for (int i = 0; i < 4; i++) begin
      step(i[0], ~i[0], 1'b0);
    end
`ifdef TUG_AUTO_RESTART_EN
    chk("auto_presses_leds", leds, 9'b000010000);
    chk("auto_presses_active", {8'b0, round_active}, 9'd1);
`endif

    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Reset in the cycle a winning press is sampled
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 1'b1);
    chk("rst_on_win_leds", leds, 9'b000010000);
    chk("rst_on_win_no_pulse", {8'b0, win_l}, 9'd0);
    chk("rst_on_win_active", {8'b0, round_active}, 9'd1);
    step(1'b0, 1'b0, 1'b0);

    // Reset mid-HOLD
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("rst_mid_hold_leds", leds, 9'b000010000);
    chk("rst_mid_hold_active", {8'b0, round_active}, 9'd1);
    chk("rst_mid_hold_wins", {7'b0, win_l, win_r}, 9'd0);
    step(1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
